// File: rtl/dma_pkg.sv
// Shared DMA definitions: DW-enable encodings, tag width default,
// and dwen helpers used by the completion packer and read controller.
package dma_pkg;

  localparam int TAG_W_DEF = 8;

  localparam logic [3:0] DWEN_1 = 4'b0001;
  localparam logic [3:0] DWEN_2 = 4'b0011;
  localparam logic [3:0] DWEN_3 = 4'b0111;
  localparam logic [3:0] DWEN_4 = 4'b1111;

  function automatic logic [3:0] dwen_of(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = DWEN_1;
      3'd2:    m = DWEN_2;
      3'd3:    m = DWEN_3;
      3'd4:    m = DWEN_4;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] dwen_bytes(input logic [3:0] dwen);
    logic [2:0] c;
    c = {2'b0, dwen[0]} + {2'b0, dwen[1]}
      + {2'b0, dwen[2]} + {2'b0, dwen[3]};
    return {c, 2'b00};
  endfunction

endpackage

// File: rtl/dw_compactor.sv
// Lane-0 justifies the lowest contiguous run of valid DWs in a beat
// and reports its length plus whether the mask was contiguous.
module dw_compactor (
  input  logic [3:0]   dwen,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic [2:0]   n,
  output logic         contig
);

  logic [1:0]   start;
  logic         found;
  logic         stop;
  logic [3:0]   run;
  logic [127:0] shifted;

  always_comb begin
    start = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && dwen[i]) begin
        start = 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    n    = 3'd0;
    stop = 1'b0;
    run  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(start) && !stop) begin
        if (dwen[i]) begin
          n      = n + 3'd1;
          run[i] = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  assign shifted = din >> {start, 5'b00000};

  always_comb begin
    dout = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n))
        dout[32*k +: 32] = shifted[32*k +: 32];
    end
  end

  assign contig = (run == dwen);

endmodule

// File: rtl/completion_packer.sv
// Re-packs completion payload beats into lane-0 justified words,
// flushing the residual as one partial word at completion end.
module completion_packer
  import dma_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int DW_LANES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  cpl_valid,
  output logic                  cpl_ready,
  input  logic                  cpl_sop,
  input  logic                  cpl_eop,
  input  logic                  cpl_last,
  input  logic [TAG_W-1:0]      cpl_tag,
  input  logic [32*DW_LANES-1:0] cpl_data,
  input  logic [DW_LANES-1:0]   cpl_dwen,
  output logic                  packer_valid,
  output logic [TAG_W-1:0]      packer_tag,
  output logic [32*DW_LANES-1:0] packer_dout,
  output logic [DW_LANES-1:0]   packer_dout_dwen,
  output logic                  packer_done,
  output logic                  err_seq
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state, state_n;
  logic [1:0]       r, r_n;
  logic [95:0]      res, res_n;
  logic [TAG_W-1:0] tag_q, tag_n;
  logic             open, open_n;
  logic             flast, flast_n;

  logic             v_n, done_n, err_n;
  logic [TAG_W-1:0] otag_n;
  logic [127:0]     dout_n;
  logic [3:0]       dwen_n;

  logic [127:0]     cpacked;
  logic [2:0]       n;
  logic             contig;

  dw_compactor u_cmp (
    .dwen   (cpl_dwen),
    .din    (cpl_data),
    .dout   (cpacked),
    .n      (n),
    .contig (contig)
  );

  logic             acc;
  logic [1:0]       base_r;
  logic [95:0]      res_eff;
  logic [2:0]       t;
  logic [223:0]     merged;
  logic [TAG_W-1:0] tag_use;

  // A sop always starts clean, discarding any stale residual.
  assign acc     = cpl_valid && cpl_ready;
  assign base_r  = cpl_sop ? 2'd0 : r;
  assign res_eff = cpl_sop ? 96'd0 : res;
  assign t       = {1'b0, base_r} + n;
  assign merged  = ({96'd0, cpacked} << {base_r, 5'b00000})
                 | {128'd0, res_eff};
  assign tag_use = cpl_sop ? cpl_tag : tag_q;

  always_comb begin
    state_n = state;
    r_n     = r;
    res_n   = res;
    tag_n   = tag_q;
    open_n  = open;
    flast_n = flast;
    v_n     = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    otag_n  = '0;
    dout_n  = '0;
    dwen_n  = 4'b0000;
    if (state == FLUSH) begin
      v_n     = 1'b1;
      dout_n  = {32'd0, res};
      dwen_n  = dwen_of({1'b0, r});
      done_n  = flast;
      otag_n  = tag_q;
      r_n     = 2'd0;
      res_n   = '0;
      state_n = RUN;
    end else if (acc) begin
      if (cpl_dwen == 4'b0000) begin
        err_n = 1'b1;
      end else begin
        err_n = !contig || (cpl_sop && r != 2'd0)
             || (!cpl_sop && !open);
        if (cpl_sop)
          tag_n = cpl_tag;
        open_n = !cpl_eop;
        if (t >= 3'd4) begin
          v_n    = 1'b1;
          otag_n = tag_use;
          dout_n = merged[127:0];
          dwen_n = DWEN_4;
          r_n    = t[1:0];
          res_n  = merged[223:128];
          if (cpl_eop && t == 3'd4) begin
            done_n = cpl_last;
          end else if (cpl_eop) begin
            state_n = FLUSH;
            flast_n = cpl_last;
          end
        end else if (cpl_eop) begin
          v_n    = 1'b1;
          otag_n = tag_use;
          dout_n = merged[127:0];
          dwen_n = dwen_of(t);
          done_n = cpl_last;
          r_n    = 2'd0;
          res_n  = '0;
        end else begin
          r_n   = t[1:0];
          res_n = merged[95:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= RUN;
      r                <= 2'd0;
      res              <= '0;
      tag_q            <= '0;
      open             <= 1'b0;
      flast            <= 1'b0;
      cpl_ready        <= 1'b0;
      packer_valid     <= 1'b0;
      packer_tag       <= '0;
      packer_dout      <= '0;
      packer_dout_dwen <= '0;
      packer_done      <= 1'b0;
      err_seq          <= 1'b0;
    end else begin
      state            <= state_n;
      r                <= r_n;
      res              <= res_n;
      tag_q            <= tag_n;
      open             <= open_n;
      flast            <= flast_n;
      cpl_ready        <= (state_n == RUN);
      packer_valid     <= v_n;
      packer_tag       <= otag_n;
      packer_dout      <= dout_n;
      packer_dout_dwen <= dwen_n;
      packer_done      <= done_n;
      err_seq          <= err_n;
    end
  end

endmodule
